// File: rtl/board_level_data_block_receiver_pkg.sv
// Shared definitions for the block receiver: FSM state encodings, byte-event
// codes and small elaboration-time helpers.
package board_level_data_block_receiver_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECV    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_START = 2'd1,
    EV_END   = 2'd2,
    EV_BYTE  = 2'd3
  } event_e;

  // A start marker wins over an end marker raised in the same event.
  function automatic event_e decode_event(input logic valid,
                                          input logic frame_start,
                                          input logic frame_end);
    event_e ev;
    if (!valid)           ev = EV_NONE;
    else if (frame_start) ev = EV_START;
    else if (frame_end)   ev = EV_END;
    else                  ev = EV_BYTE;
    return ev;
  endfunction

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/board_level_data_block_receiver.sv
// Reassembles BYTE_N-byte blocks from the byte-event stream and presents them
// on a valid/ready holding register, flagging malformed and dropped frames.
module board_level_data_block_receiver
  import board_level_data_block_receiver_pkg::*;
#(
  parameter int BYTE_N    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic                 rx_frame_start,
  input  logic                 rx_frame_end,
  input  logic [7:0]           rx_data,
  output logic [BYTE_N*8-1:0]  data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_error,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int DW    = BYTE_N * 8;
  localparam int CNT_W = clog2(BYTE_N) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTE_N);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]        sreg_q, sreg_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;

  event_e ev;
  logic   commit;
  logic   accept;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    ferr_d  = 1'b0;
    commit  = 1'b0;
    ev      = decode_event(rx_valid, rx_frame_start, rx_frame_end);

    case (state_q)
      ST_IDLE: begin
        if (ev == EV_START) begin
          state_d = ST_RECV;
          cnt_d   = '0;
        end
      end
      ST_RECV: begin
        case (ev)
          EV_BYTE: begin
            if (cnt_q == CNT_FULL) begin
              ferr_d  = 1'b1;
              state_d = ST_DISCARD;
            end else begin
              sreg_d = {rx_data, sreg_q[DW-1:8]};
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end
          EV_END: begin
            state_d = ST_IDLE;
            if (cnt_q == CNT_FULL) commit = 1'b1;
            else                   ferr_d = 1'b1;
          end
          EV_START: begin
            ferr_d = 1'b1;
            cnt_d  = '0;
          end
          default: ;
        endcase
      end
      ST_DISCARD: begin
        // The error was already reported on the surplus byte; stay quiet here.
        if (ev == EV_END) begin
          state_d = ST_IDLE;
        end else if (ev == EV_START) begin
          state_d = ST_RECV;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output holding register: a commit may refill it in the same cycle it drains.
  always_comb begin
    accept   = valid_q && ready;
    data_d   = data_q;
    valid_d  = valid_q && !accept;
    ovf_d    = 1'b0;
    if (commit) begin
      if (!valid_q || accept) begin
        data_d  = sreg_q;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    errcnt_d = errcnt_q;
    if ((ferr_d || ovf_d) && (errcnt_q != '1)) errcnt_d = errcnt_q + ERR_CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign overflow    = ovf_q;
  assign err_cnt     = errcnt_q;

endmodule

// File: tb/tb_board_level_data_block_receiver.sv
// Directed bench for board_level_data_block_receiver: per-cycle vector table
// plus hand-written mid-frame reset and err_cnt saturation sequences.
module tb_board_level_data_block_receiver;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic        rx_frame_start;
  logic        rx_frame_end;
  logic [7:0]  rx_data;
  logic [63:0] data;
  logic        valid;
  logic        ready;
  logic        frame_error;
  logic        overflow;
  logic [7:0]  err_cnt;

  int tests;
  int fails;

  board_level_data_block_receiver #(.BYTE_N(8), .ERR_CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_valid       (rx_valid),
    .rx_frame_start (rx_frame_start),
    .rx_frame_end   (rx_frame_end),
    .rx_data        (rx_data),
    .data           (data),
    .valid          (valid),
    .ready          (ready),
    .frame_error    (frame_error),
    .overflow       (overflow),
    .err_cnt        (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic        s;
    logic        e;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [63:0] edata;
    logic        efe;
    logic        eov;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] D1  = 64'h0807060504030201;
  localparam logic [63:0] D2  = 64'h2827262524232221;
  localparam logic [63:0] DC  = 64'hC8C7C6C5C4C3C2C1;
  localparam logic [63:0] DA  = 64'hA8A7A6A5A4A3A2A1;
  localparam logic [63:0] DD  = 64'hD8D7D6D5D4D3D2D1;
  localparam logic [63:0] D6  = 64'h1817161514131211;

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic ev, input logic [63:0] ed,
                           input logic efe, input logic eov, input logic [7:0] ec);
    check("valid", idx, {63'd0, valid}, {63'd0, ev});
    check("data", idx, data, ed);
    check("frame_error", idx, {63'd0, frame_error}, {63'd0, efe});
    check("overflow", idx, {63'd0, overflow}, {63'd0, eov});
    check("err_cnt", idx, {56'd0, err_cnt}, {56'd0, ec});
  endtask

  task automatic add(input logic r, input logic v, input logic s, input logic e,
                     input logic [7:0] d, input logic rdy, input logic ev,
                     input logic [63:0] ed, input logic efe, input logic eov,
                     input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.v = v; t.s = s; t.e = e; t.d = d; t.rdy = rdy;
    t.ev = ev; t.edata = ed; t.efe = efe; t.eov = eov; t.ec = ec;
    vecs.push_back(t);
  endtask

  // n consecutive payload bytes, none of which should disturb the outputs.
  task automatic add_bytes(input logic [7:0] first, input int n, input logic rdy,
                           input logic ev, input logic [63:0] ed, input logic [7:0] ec);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b1, 1'b0, 1'b0, first + 8'(i), rdy, ev, ed, 1'b0, 1'b0, ec);
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [7:0] d, input logic rdy);
    rx_valid = v; rx_frame_start = s; rx_frame_end = e; rx_data = d; ready = rdy;
  endtask

  task automatic do_step(input logic v, input logic s, input logic e,
                         input logic [7:0] d, input logic rdy);
    @(negedge clk);
    drive(v, s, e, d, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Good frame, then accepted.
    add(1, 0, 0, 0, 8'h00, 1, 0, 64'd0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'h00, 1, 0, 64'd0, 0, 0, 8'd0);
    add_bytes(8'h01, 8, 1'b1, 1'b0, 64'd0, 8'd0);
    add(0, 1, 0, 1, 8'h00, 1, 1, D1, 0, 0, 8'd0);
    add(0, 0, 0, 0, 8'h00, 1, 0, D1, 0, 0, 8'd0);
    // Short frame, idle noise, then a good frame.
    add(0, 1, 1, 0, 8'h00, 1, 0, D1, 0, 0, 8'd0);
    add_bytes(8'h01, 3, 1'b1, 1'b0, D1, 8'd0);
    add(0, 1, 0, 1, 8'h00, 1, 0, D1, 1, 0, 8'd1);
    add(0, 1, 0, 0, 8'h55, 1, 0, D1, 0, 0, 8'd1);
    add(0, 1, 0, 1, 8'h00, 1, 0, D1, 0, 0, 8'd1);
    add(0, 1, 1, 0, 8'h00, 0, 0, D1, 0, 0, 8'd1);
    add_bytes(8'h21, 8, 1'b0, 1'b0, D1, 8'd1);
    add(0, 1, 0, 1, 8'h00, 0, 1, D2, 0, 0, 8'd1);
    add(0, 0, 0, 0, 8'h00, 1, 0, D2, 0, 0, 8'd1);
    // Long frame: error on the 9th byte only, DISCARD then START recovers.
    add(1, 0, 0, 0, 8'h00, 1, 0, 64'd0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'h00, 1, 0, 64'd0, 0, 0, 8'd0);
    add_bytes(8'hAA, 8, 1'b1, 1'b0, 64'd0, 8'd0);
    add(0, 1, 0, 0, 8'hB2, 1, 0, 64'd0, 1, 0, 8'd1);
    add(0, 1, 0, 0, 8'hB3, 1, 0, 64'd0, 0, 0, 8'd1);
    add(0, 1, 0, 1, 8'h00, 1, 0, 64'd0, 0, 0, 8'd1);
    add(0, 1, 1, 0, 8'h00, 1, 0, 64'd0, 0, 0, 8'd1);
    add_bytes(8'hC1, 8, 1'b1, 1'b0, 64'd0, 8'd1);
    add(0, 1, 0, 1, 8'h00, 1, 1, DC, 0, 0, 8'd1);
    add(0, 0, 0, 0, 8'h00, 1, 0, DC, 0, 0, 8'd1);
    // Backpressure: second block dropped with one overflow pulse.
    add(1, 0, 0, 0, 8'h00, 0, 0, 64'd0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'h00, 0, 0, 64'd0, 0, 0, 8'd0);
    add_bytes(8'hA1, 8, 1'b0, 1'b0, 64'd0, 8'd0);
    add(0, 1, 0, 1, 8'h00, 0, 1, DA, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'h00, 0, 1, DA, 0, 0, 8'd0);
    add_bytes(8'hB1, 8, 1'b0, 1'b1, DA, 8'd0);
    add(0, 1, 0, 1, 8'h00, 0, 1, DA, 0, 1, 8'd1);
    add(0, 0, 0, 0, 8'h00, 0, 1, DA, 0, 0, 8'd1);
    add(0, 0, 0, 0, 8'h00, 1, 0, DA, 0, 0, 8'd1);
    // Accept and commit in the same cycle.
    add(0, 1, 1, 0, 8'h00, 0, 0, DA, 0, 0, 8'd1);
    add_bytes(8'hC1, 8, 1'b0, 1'b0, DA, 8'd1);
    add(0, 1, 0, 1, 8'h00, 0, 1, DC, 0, 0, 8'd1);
    add(0, 1, 1, 0, 8'h00, 0, 1, DC, 0, 0, 8'd1);
    add_bytes(8'hD1, 8, 1'b0, 1'b1, DC, 8'd1);
    add(0, 1, 0, 1, 8'h00, 1, 1, DD, 0, 0, 8'd1);
    add(0, 0, 0, 0, 8'h00, 1, 0, DD, 0, 0, 8'd1);
    // Restart at byte 4 (start+end flags together decode as START).
    add(1, 0, 0, 0, 8'h00, 0, 0, 64'd0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'h00, 0, 0, 64'd0, 0, 0, 8'd0);
    add_bytes(8'h01, 3, 1'b0, 1'b0, 64'd0, 8'd0);
    add(0, 1, 1, 1, 8'h00, 0, 0, 64'd0, 1, 0, 8'd1);
    add_bytes(8'h11, 8, 1'b0, 1'b0, 64'd0, 8'd1);
    add(0, 1, 0, 1, 8'h00, 0, 1, D6, 0, 0, 8'd1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, vecs[i].rdy);
        #2;
        check_all(i, vecs[i].ev, vecs[i].edata, vecs[i].efe, vecs[i].eov, vecs[i].ec);
        #1 rst_n = 1'b1;
      end else begin
        do_step(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].rdy);
        check_all(i, vecs[i].ev, vecs[i].edata, vecs[i].efe, vecs[i].eov, vecs[i].ec);
      end
    end

    // Async reset in the middle of a frame clears everything at once.
    do_step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check_all(1000, 1'b1, D6, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0, 1'b0, 8'(i + 1), 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all(1001, 1'b0, 64'd0, 1'b0, 1'b0, 8'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_all(1002 + i, 1'b0, 64'd0, 1'b0, 1'b0, 8'd0);
    end
    do_step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) do_step(1'b1, 1'b0, 1'b0, 8'h21 + 8'(i), 1'b0);
    do_step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check_all(1005, 1'b1, D2, 1'b0, 1'b0, 8'd0);

    // err_cnt saturation with a stream of empty frames.
    for (int i = 0; i < 300; i++) begin
      do_step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      do_step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      if (i == 0)   check_all(2000, 1'b1, D2, 1'b1, 1'b0, 8'd1);
      if (i == 253) check_all(2001, 1'b1, D2, 1'b1, 1'b0, 8'd254);
    end
    check_all(2002, 1'b1, D2, 1'b1, 1'b0, 8'hFF);
    do_step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_all(2003, 1'b0, D2, 1'b0, 1'b0, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
